bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq_pkg.sv | 27 ++
 rtl/bin_to_bcd_seq_if.sv | 29 ++
 rtl/bin_to_bcd_seq_seg7_decode.sv | 32 +++
 rtl/bin_to_bcd_seq.sv | 147 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, digit/segment slice widths and active-low
// 7-segment patterns (bit0=a ... bit6=g).
package bin_to_bcd_seq_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for bin_to_bcd_seq.
//   master: drives start, bin_in, blank_lz; observes results.
//   slave : the converter; drives busy, done, bcd_out, hex_out, overflow.
interface bin_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    import bin_to_bcd_seq_pkg::*;

    logic                      start;
    logic [WIDTH-1:0]          bin_in;
    logic                      blank_lz;
    logic                      busy;
    logic                      done;
    logic [DIGIT_W*DIGITS-1:0] bcd_out;
    logic [SEG_W*DIGITS-1:0]   hex_out;
    logic                      overflow;

    modport master (
        output start, bin_in, blank_lz,
        input  busy, done, bcd_out, hex_out, overflow
    );

    modport slave (
        input  start, bin_in, blank_lz,
        output busy, done, bcd_out, hex_out, overflow
    );

endinterface

// File: rtl/bin_to_bcd_seq_seg7_decode.sv
// One-digit BCD to active-low 7-segment decoder.
//   bcd_i   : BCD digit (10..15 decode as blank)
//   blank_i : force the digit dark
//   seg_c   : combinational segment pattern, bit0=a ... bit6=g
module bin_to_bcd_seq_seg7_decode
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd_i,
    input  logic               blank_i,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with 7-segment outputs.
// Converts one input bit per clock; results are registered on the FIN cycle.
//   Clock, Resetn : clock and asynchronous active-low reset
//   bus (slave)   : start/bin_in/blank_lz request, busy/done handshake,
//                   bcd_out, hex_out (active-low) and overflow results
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic             Clock,
    input  logic             Resetn,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int unsigned SCR_W = DIGIT_W * DIGITS;
    localparam int unsigned HEX_W = SEG_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic               blank_q, blank_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic [HEX_W-1:0]   hex_q, hex_d;
    logic               ovf_q, ovf_d;

    logic [SCR_W-1:0]       adj_c;
    logic [SCR_W+WIDTH-1:0] shifted_c;
    logic [DIGITS-1:0]      blank_c;
    logic                   all_zero_c;
    logic [HEX_W-1:0]       hex_c;

    // Leading-zero blanking: digit k>0 goes dark when it and all above are zero.
    always_comb begin
        blank_c    = '0;
        all_zero_c = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            all_zero_c = all_zero_c & (scratch_q[k*DIGIT_W +: DIGIT_W] == 4'd0);
            blank_c[k] = blank_q & all_zero_c;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bin_to_bcd_seq_seg7_decode u_dec (
            .bcd_i   (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .blank_i (blank_c[g]),
            .seg_c   (hex_c[g*SEG_W +: SEG_W])
        );
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        blank_d   = blank_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        hex_d     = hex_q;
        ovf_d     = ovf_q;
        adj_c     = scratch_q;
        shifted_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_CONV;
                    shift_d   = bus.bin_in;
                    blank_d   = bus.blank_lz;
                    scratch_d = '0;
                    acc_d     = 1'b0;
                    cnt_d     = CNT_W'(WIDTH);
                end
            end
            ST_CONV: begin
                for (int k = 0; k < int'(DIGITS); k++) begin
                    if (scratch_q[k*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                        adj_c[k*DIGIT_W +: DIGIT_W] = scratch_q[k*DIGIT_W +: DIGIT_W] + 4'd3;
                    end
                end
                shifted_c = {adj_c, shift_q} << 1;
                scratch_d = shifted_c[SCR_W+WIDTH-1:WIDTH];
                shift_d   = shifted_c[WIDTH-1:0];
                // Any bit leaving the top digit means the value needs more digits.
                acc_d     = acc_q | adj_c[SCR_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                bcd_d   = scratch_q;
                hex_d   = hex_c;
                ovf_d   = acc_q;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CONV);
    end

    // State and output registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            blank_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            hex_q     <= '1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            blank_q   <= blank_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            hex_q     <= hex_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.hex_out  = hex_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance, directed and
// random operands checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) if3 ();
    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) if2 ();

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (if3)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (if2)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int sel    = 3;

    logic        cur_done, cur_busy, cur_ovf;
    logic [11:0] cur_bcd;
    logic [20:0] cur_hex;

    always_comb begin
        if (sel == 2) begin
            cur_done = if2.done;
            cur_busy = if2.busy;
            cur_ovf  = if2.overflow;
            cur_bcd  = {4'h0, if2.bcd_out};
            cur_hex  = {7'h00, if2.hex_out};
        end else begin
            cur_done = if3.done;
            cur_busy = if3.busy;
            cur_ovf  = if3.overflow;
            cur_bcd  = if3.bcd_out;
            cur_hex  = if3.hex_out;
        end
    end

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: digits by repeated division, blanking above the top non-zero digit.
    function automatic void model(input int v, input bit blz, input int nd,
                                  output logic [11:0] bcd, output logic [20:0] hex,
                                  output bit ovf);
        int p = 1;
        int t = v;
        int msnz = 0;
        int d [3];
        for (int i = 0; i < nd; i++) p = p * 10;
        ovf = (v >= p);
        bcd = '0;
        hex = '0;
        for (int k = 0; k < nd; k++) begin
            d[k] = t % 10;
            t    = t / 10;
            bcd[k*4 +: 4] = 4'(d[k]);
            if (d[k] != 0) msnz = k;
        end
        for (int k = 0; k < nd; k++) begin
            hex[k*7 +: 7] = (blz && k > msnz) ? 7'h7f : seg_tab[d[k]];
        end
    endfunction

    task automatic drive(input int s, input int v, input bit blz, input bit st);
        if (s == 2) begin
            if2.bin_in = 8'(v); if2.blank_lz = blz; if2.start = st;
        end else begin
            if3.bin_in = 8'(v); if3.blank_lz = blz; if3.start = st;
        end
    endtask

    task automatic convert(input int s, input int v, input bit blz, input string tag);
        logic [11:0] eb;
        logic [20:0] eh;
        bit          eo;
        int          lat;
        int          busy_n;
        model(v, blz, (s == 2) ? 2 : 3, eb, eh, eo);
        @(negedge clk);
        sel = s;
        drive(s, v, blz, 1'b1);
        @(posedge clk); #1;
        drive(s, v, blz, 1'b0);
        lat = 0;
        busy_n = 0;
        while (!cur_done && lat < 40) begin
            if (cur_busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, "_bcd"}, 32'(cur_bcd), 32'(eb));
        check({tag, "_hex"}, 32'(cur_hex), 32'(eh));
        check({tag, "_ovf"}, 32'(cur_ovf), 32'(eo));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(cur_done), 32'd0);
    endtask

    initial begin
        int lat;
        int n_done;
        drive(3, 0, 1'b0, 1'b0);
        drive(2, 0, 1'b0, 1'b0);

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(if3.busy), 32'd0);
        check("rst_done", 32'(if3.done), 32'd0);
        check("rst_bcd",  32'(if3.bcd_out), 32'd0);
        check("rst_hex",  32'(if3.hex_out), 32'h1fffff);
        check("rst_ovf",  32'(if3.overflow), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Directed cases
        convert(3, 0,   1'b1, "zero_blz");
        convert(3, 255, 1'b0, "v255");
        convert(3, 7,   1'b1, "v7_blz");
        convert(3, 9,   1'b1, "v9_blz");
        convert(3, 10,  1'b1, "v10_blz");
        convert(3, 100, 1'b1, "v100_blz");
        convert(2, 123, 1'b0, "d2_v123");
        convert(2, 99,  1'b1, "d2_v99");
        convert(2, 100, 1'b1, "d2_v100");

        // Start while busy ignored; bin_in changes after acceptance ignored
        sel = 3;
        @(negedge clk);
        drive(3, 42, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(3, 42, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(3, 99, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(3, 17, 1'b1, 1'b0);
        lat = 0;
        while (!cur_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_done_seen", 32'(cur_done), 32'd1);
        check("ign_bcd", 32'(if3.bcd_out), 32'h042);
        n_done = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (cur_done) n_done++;
        end
        check("ign_no_second_done", 32'(n_done), 32'd0);
        check("hold_bcd", 32'(if3.bcd_out), 32'h042);

        // Asynchronous reset mid-conversion
        @(negedge clk);
        drive(3, 200, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(3, 200, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(if3.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(if3.busy), 32'd0);
        check("arst_done", 32'(if3.done), 32'd0);
        check("arst_bcd",  32'(if3.bcd_out), 32'd0);
        check("arst_hex",  32'(if3.hex_out), 32'h1fffff);
        check("arst_ovf",  32'(if3.overflow), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        n_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if3.done) n_done++;
        end
        check("arst_no_done", 32'(n_done), 32'd0);
        convert(3, 200, 1'b0, "after_rst_v200");

        // Random operands
        for (int i = 0; i < 20; i++) begin
            convert(3, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rnd3");
        end
        for (int i = 0; i < 12; i++) begin
            convert(2, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rnd2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
